// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 timing constants for the VGA raster generator.
package vga_timing_pkg;

  // hs/vs hold the logical "sync window active" flag; polarity is applied at the output pins.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
  } vga_ctl_t;

  localparam vga_ctl_t VGA_CTL_IDLE = '{hs: 1'b0, vs: 1'b0, de: 1'b0};

  localparam int DEF_H_ACT   = 640;
  localparam int DEF_H_FRONT = 16;
  localparam int DEF_H_SYNC  = 96;
  localparam int DEF_H_BACK  = 48;
  localparam int DEF_V_ACT   = 480;
  localparam int DEF_V_FRONT = 10;
  localparam int DEF_V_SYNC  = 2;
  localparam int DEF_V_BACK  = 33;
  localparam int DEF_PIX_LAT = 2;
  localparam int DEF_CW      = 12;

  function automatic logic sync_level(input logic active, input bit pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_ctl_delay.sv
// Fixed-depth delay line for the sync/blank control word; DEPTH=0 degenerates to a wire.
module vga_ctl_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  input  vga_ctl_t ctl,
  output vga_ctl_t ctl_delayed
);

  generate
    if (DEPTH == 0) begin : g_wire
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ reset_n;
      assign ctl_delayed    = ctl;
    end else begin : g_pipe
      vga_ctl_t pipe [DEPTH];

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          for (int i = 0; i < DEPTH; i++) pipe[i] <= VGA_CTL_IDLE;
        end else begin
          pipe[0] <= ctl;
          for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
        end
      end

      assign ctl_delayed = pipe[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: issues pixel requests PIX_LAT cycles ahead and delays
// sync/blank so the returned RGB lands exactly on the active window.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACT   = DEF_H_ACT,
  parameter int H_FRONT = DEF_H_FRONT,
  parameter int H_SYNC  = DEF_H_SYNC,
  parameter int H_BACK  = DEF_H_BACK,
  parameter int V_ACT   = DEF_V_ACT,
  parameter int V_FRONT = DEF_V_FRONT,
  parameter int V_SYNC  = DEF_V_SYNC,
  parameter int V_BACK  = DEF_V_BACK,
  parameter bit H_POL   = 1'b0,
  parameter bit V_POL   = 1'b0,
  parameter int PIX_LAT = DEF_PIX_LAT,
  parameter int CW      = DEF_CW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic [7:0]    r_in,
  input  logic [7:0]    g_in,
  input  logic [7:0]    b_in,
  output logic          req_valid,
  output logic [CW-1:0] req_x,
  output logic [CW-1:0] req_y,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    red,
  output logic [7:0]    green,
  output logic [7:0]    blue,
  output logic          h_sync,
  output logic          v_sync,
  output logic          vga_blank_n,
  output logic          vga_sync_n,
  output logic          vga_clk
);

  localparam int H_TOT   = H_ACT + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOT   = V_ACT + V_FRONT + V_SYNC + V_BACK;
  localparam int MAX_TOT = (H_TOT > V_TOT) ? H_TOT : V_TOT;

  generate
    if ((64'd1 << CW) <= 64'(MAX_TOT - 1)) begin : g_bad_cw
      $error("vga_timing_gen: CW=%0d too narrow for total %0d", CW, MAX_TOT);
    end
    if (H_ACT < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACT < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_size
      $error("vga_timing_gen: every porch/sync/active size must be at least 1");
    end
    if (PIX_LAT < 0 || PIX_LAT > 8) begin : g_bad_lat
      $error("vga_timing_gen: PIX_LAT=%0d outside 0..8", PIX_LAT);
    end
  endgenerate

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOT - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOT - 1);
  localparam logic [CW-1:0] H_ACT_C  = CW'(H_ACT);
  localparam logic [CW-1:0] V_ACT_C  = CW'(V_ACT);
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACT + H_FRONT);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACT + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACT + V_FRONT);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACT + V_FRONT + V_SYNC - 1);

  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  vga_ctl_t      ctl_next;
  vga_ctl_t      ctl0;
  vga_ctl_t      ctl_d;

  // Disabled raster parks at the origin so the first enabled cycle starts a fresh frame.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!enable) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  always_comb begin
    ctl_next = VGA_CTL_IDLE;
    if (enable) begin
      ctl_next.de = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
      ctl_next.hs = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
      ctl_next.vs = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctl0        <= VGA_CTL_IDLE;
      req_x       <= '0;
      req_y       <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ctl0        <= ctl_next;
      req_x       <= h_cnt;
      req_y       <= v_cnt;
      line_start  <= enable && (h_cnt == '0);
      frame_start <= enable && (h_cnt == '0) && (v_cnt == '0);
    end
  end

  assign req_valid = ctl0.de;

  vga_ctl_delay #(
    .DEPTH(PIX_LAT)
  ) u_ctl_delay (
    .clk        (clk),
    .reset_n    (reset_n),
    .ctl        (ctl0),
    .ctl_delayed(ctl_d)
  );

  // ctl_d is aligned with the returning pixel data, so one register puts both on the pins together.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      vga_blank_n <= 1'b0;
      h_sync      <= ~H_POL;
      v_sync      <= ~V_POL;
    end else begin
      red         <= ctl_d.de ? r_in : '0;
      green       <= ctl_d.de ? g_in : '0;
      blue        <= ctl_d.de ? b_in : '0;
      vga_blank_n <= ctl_d.de;
      h_sync      <= sync_level(ctl_d.hs, H_POL);
      v_sync      <= sync_level(ctl_d.vs, V_POL);
    end
  end

  assign vga_sync_n = 1'b1;
  assign vga_clk    = ~clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: small raster A (PIX_LAT=2, active-low syncs) with a pixel-source
// model and scoreboard, plus tiny raster B (PIX_LAT=0, active-high syncs) for timing checks.
`timescale 1ns/1ps
module tb_vga_timing_gen;

  localparam int A_HA = 16, A_HF = 2, A_HS = 3, A_HB = 2;
  localparam int A_VA = 6,  A_VF = 1, A_VS = 2, A_VB = 1;
  localparam int A_LAT   = 2;
  localparam int A_FRAME = 230;
  localparam int B_FRAME = 48;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n, en_a, en_b;

  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;
  logic        req_valid_a, line_start_a, frame_start_a, h_sync_a, v_sync_a;
  logic        blank_n_a, sync_n_a, vga_clk_a;
  logic [11:0] req_x_a, req_y_a;
  logic [7:0]  red_a, green_a, blue_a;
  logic        req_valid_b, line_start_b, frame_start_b, h_sync_b, v_sync_b;
  logic        blank_n_b, sync_n_b, vga_clk_b;
  logic [11:0] req_x_b, req_y_b;
  logic [7:0]  red_b, green_b, blue_b;

  vga_timing_gen #(
    .H_ACT(A_HA), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
    .V_ACT(A_VA), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
    .H_POL(1'b0), .V_POL(1'b0), .PIX_LAT(A_LAT), .CW(12)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .enable(en_a),
    .r_in(r_a), .g_in(g_a), .b_in(b_a),
    .req_valid(req_valid_a), .req_x(req_x_a), .req_y(req_y_a),
    .line_start(line_start_a), .frame_start(frame_start_a),
    .red(red_a), .green(green_a), .blue(blue_a),
    .h_sync(h_sync_a), .v_sync(v_sync_a), .vga_blank_n(blank_n_a),
    .vga_sync_n(sync_n_a), .vga_clk(vga_clk_a)
  );

  vga_timing_gen #(
    .H_ACT(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACT(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .PIX_LAT(0), .CW(12)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .enable(en_b),
    .r_in(r_b), .g_in(g_b), .b_in(b_b),
    .req_valid(req_valid_b), .req_x(req_x_b), .req_y(req_y_b),
    .line_start(line_start_b), .frame_start(frame_start_b),
    .red(red_b), .green(green_b), .blue(blue_b),
    .h_sync(h_sync_b), .v_sync(v_sync_b), .vga_blank_n(blank_n_b),
    .vga_sync_n(sync_n_b), .vga_clk(vga_clk_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard: expected {blue,green,red} per requested pixel of raster A
  logic [23:0] exp_q[$];
  logic [23:0] src_q[$];
  int exp_px = 0;
  int exp_py = 0;

  // pixel source for A: returns {~x, y, x} exactly A_LAT cycles after the request
  initial begin
    logic [23:0] v;
    {b_a, g_a, r_a} = 24'ha5a5a5;
    {b_b, g_b, r_b} = 24'h5a5a5a;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        src_q.delete();
        {b_a, g_a, r_a} = 24'ha5a5a5;
      end else begin
        if (frame_start_a) begin
          exp_px = 0;
          exp_py = 0;
        end
        if (req_valid_a) begin
          chk("req_x", req_x_a, exp_px);
          chk("req_y", req_y_a, exp_py);
          v = {~req_x_a[7:0], req_y_a[7:0], req_x_a[7:0]};
          exp_q.push_back({~8'(exp_px), 8'(exp_py), 8'(exp_px)});
          exp_px++;
          if (exp_px == A_HA) begin
            exp_px = 0;
            exp_py = (exp_py == A_VA - 1) ? 0 : exp_py + 1;
          end
        end else begin
          v = 24'ha5a5a5;
        end
        src_q.push_back(v);
        if (src_q.size() > A_LAT) v = src_q.pop_front();
        else v = 24'ha5a5a5;
        {b_a, g_a, r_a} = v;
      end
    end
  end

  // monitor: whenever A presents active video, pop and compare
  initial begin
    forever begin
      @(posedge clk); #1;
      if (!reset_n) exp_q.delete();
      else if (blank_n_a) begin
        if (exp_q.size() == 0) chk("pixel_expected", 0, 1);
        else chk("pixel_rgb", {blue_a, green_a, red_a}, exp_q.pop_front());
      end else begin
        chk("blank_rgb_zero", {blue_a, green_a, red_a}, 0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic measure_a(output int hs_lo, output int vs_lo, output int de_hi, output int fs);
    hs_lo = 0; vs_lo = 0; de_hi = 0; fs = 0;
    repeat (A_FRAME) begin
      @(negedge clk);
      if (!h_sync_a) hs_lo++;
      if (!v_sync_a) vs_lo++;
      if (blank_n_a) de_hi++;
      if (frame_start_a) fs++;
    end
  endtask

  initial begin
    int k, hs, vs, de, fs, max_x, max_y, seq_err, rgb_err;
    logic prev_vs, prev_ls;
    logic [11:0] prev_x;

    reset_n = 1'b0; en_a = 1'b0; en_b = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_valid", req_valid_a, 0);
    chk("rst_line_start", line_start_a, 0);
    chk("rst_frame_start", frame_start_a, 0);
    chk("rst_req_xy", {req_x_a, req_y_a}, 0);
    chk("rst_rgb", {red_a, green_a, blue_a}, 0);
    chk("rst_blank_n", blank_n_a, 0);
    chk("rst_h_sync_lowpol", h_sync_a, 1);
    chk("rst_v_sync_lowpol", v_sync_a, 1);
    chk("rst_h_sync_highpol", h_sync_b, 0);
    chk("rst_v_sync_highpol", v_sync_b, 0);
    chk("sync_n_const", {sync_n_a, sync_n_b}, 2'b11);
    chk("vga_clk_inverted", {vga_clk_a, vga_clk_b}, 2'b11);

    en_a = 1'b1; en_b = 1'b1; reset_n = 1'b1;
    @(negedge clk);
    chk("start_frame_start", frame_start_a, 1);
    chk("start_line_start", line_start_a, 1);
    chk("start_req", {req_valid_a, req_x_a, req_y_a}, {1'b1, 24'h0});

    k = 0;
    while (!blank_n_a && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("first_blank_rise_latency", k, 3);

    measure_a(hs, vs, de, fs);
    chk("a_h_sync_low_cycles", hs, 30);
    chk("a_v_sync_low_cycles", vs, 46);
    chk("a_blank_n_high_cycles", de, 96);
    chk("a_frame_start_count", fs, 1);

    // raster B: counter wraps, sync widths, vs edges aligned to line_start
    max_x = 0; max_y = 0; seq_err = 0; rgb_err = 0; hs = 0; vs = 0; de = 0; fs = 0;
    prev_vs = v_sync_b; prev_ls = line_start_b; prev_x = req_x_b;
    repeat (2 * B_FRAME) begin
      @(negedge clk);
      if (int'(req_x_b) > max_x) max_x = int'(req_x_b);
      if (int'(req_y_b) > max_y) max_y = int'(req_y_b);
      if (req_x_b != ((prev_x == 12'd7) ? 12'd0 : prev_x + 12'd1)) seq_err++;
      if (v_sync_b != prev_vs) chk("b_vs_edge_on_line_start", prev_ls, 1);
      if (blank_n_b ? (red_b != 8'h5a) : (red_b != 8'h00)) rgb_err++;
      if (h_sync_b) hs++;
      if (v_sync_b) vs++;
      if (blank_n_b) de++;
      if (frame_start_b) fs++;
      prev_vs = v_sync_b; prev_ls = line_start_b; prev_x = req_x_b;
    end
    chk("b_max_x", max_x, 7);
    chk("b_max_y", max_y, 5);
    chk("b_x_sequence_errors", seq_err, 0);
    chk("b_rgb_gating_errors", rgb_err, 0);
    chk("b_h_sync_high_cycles", hs, 24);
    chk("b_v_sync_high_cycles", vs, 16);
    chk("b_blank_n_high_cycles", de, 24);
    chk("b_frame_start_count", fs, 2);

    k = 0;
    while (!frame_start_b && k < 100) begin @(negedge clk); k++; end
    k = 0;
    do begin @(negedge clk); k++; end while (!frame_start_b && k < 100);
    chk("b_frame_period", k, B_FRAME);

    // drop enable on A mid-active
    k = 0;
    while (!(req_valid_a && req_x_a == 12'd10 && req_y_a == 12'd3) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("drop_point_reached", k < 1000, 1);
    en_a = 1'b0;
    @(negedge clk);
    chk("drop_req_idle", {req_valid_a, line_start_a, frame_start_a}, 3'b000);
    repeat (2) @(negedge clk);
    chk("drop_last_pixel_out", blank_n_a, 1);
    @(negedge clk);
    chk("drop_outputs_idle", {blank_n_a, h_sync_a, v_sync_a, red_a}, {3'b011, 8'h00});
    repeat (3) @(negedge clk);
    chk("disabled_at_origin", {req_valid_a, req_x_a, req_y_a}, 25'h0);
    en_a = 1'b1;
    @(negedge clk);
    chk("reenable_frame_start", {frame_start_a, line_start_a}, 2'b11);
    chk("reenable_req", {req_valid_a, req_x_a, req_y_a}, {1'b1, 24'h0});
    repeat (A_FRAME) @(negedge clk);

    // asynchronous reset in the middle of an active line
    k = 0;
    while (!(req_valid_a && req_x_a == 12'd5) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk("mid_line_reached", k < 1000, 1);
    chk("pre_reset_blank_n", blank_n_a, 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_rgb", {red_a, green_a, blue_a}, 0);
    chk("async_rst_blank_sync", {blank_n_a, h_sync_a, v_sync_a}, 3'b011);
    chk("async_rst_req", {req_valid_a, line_start_a, frame_start_a, req_x_a, req_y_a}, 27'h0);
    chk("async_rst_b_sync", {h_sync_b, v_sync_b}, 2'b00);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_rst_frame_start", frame_start_a, 1);
    chk("post_rst_req", {req_valid_a, req_x_a, req_y_a}, {1'b1, 24'h0});
    repeat (A_FRAME + 10) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
